// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, frame geometry and the default baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int FRAME_BITS        = 10;
  localparam int BAUD_DIV_9600_50M = 5208;

  // A divisor of 1 still needs a 1-bit counter.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester above last_idx_i (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_idx_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               valid_o
);

  // The last granted index is visited last, which gives the fairness rotation.
  always_comb begin
    int   cand;
    logic found;
    grant_o     = '0;
    grant_idx_o = last_idx_i;
    found       = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_idx_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDX_W'(cand);
        found         = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter: grants one requester's byte and sends it as an 8N1 frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = BAUD_DIV_9600_50M,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_uart,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx
);

  localparam int                CNT_W     = cntWidth(BAUD_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);
  localparam logic [3:0]        DATA_LAST = 4'(FRAME_BITS - 2);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [3:0]         cnt1_q, cnt1_d;
  logic [7:0]         shift_q;
  logic               tx_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [IDX_W-1:0]   grantIdx_q;

  logic [NUM_REQ-1:0] arbGrant;
  logic [IDX_W-1:0]   arbIdx;
  logic               reqValid;
  logic [7:0]         selByte;
  logic               baudEnd;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i       (req),
    .last_idx_i  (grantIdx_q),
    .grant_o     (arbGrant),
    .grant_idx_o (arbIdx),
    .valid_o     (reqValid)
  );

  assign selByte = req_data[{arbIdx, 3'b000} +: 8];
  assign baudEnd = (cnt0_q == CNT_LAST);
  assign cnt0_d  = baudEnd ? '0 : cnt0_q + CNT_W'(1);
  assign cnt1_d  = baudEnd ? cnt1_q + 4'd1 : cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      grantIdx_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          cnt0_q <= '0;
          cnt1_q <= '0;
          tx_q   <= 1'b1;
          if (reqValid) begin
            shift_q    <= selByte;
            grantIdx_q <= arbIdx;
            ack_q      <= arbGrant;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          cnt0_q <= cnt0_d;
          cnt1_q <= cnt1_d;
          if (baudEnd) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt0_q <= cnt0_d;
          cnt1_q <= cnt1_d;
          if (baudEnd) begin
            if (cnt1_q == DATA_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end
        end
        STOP: begin
          cnt0_q <= cnt0_d;
          if (baudEnd && cnt1_q == BIT_LAST) begin
            cnt1_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt1_q <= cnt1_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign tx_uart   = tx_q;
  assign busy      = busy_q;
  assign grant_idx = grantIdx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single-grant frames plus multi-cycle corner sequences.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int BD    = 4;
  localparam int FRAME = 10 * BD;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]  ack;
  logic             tx_uart;
  logic             busy;
  logic [1:0]       grant_idx;

  int vecCount = 0;
  int errCount = 0;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .BAUD_DIV(BD), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .tx_uart   (tx_uart),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  expAck;
    logic [1:0]  expIdx;
    logic [7:0]  expByte;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
    req      = r;
    req_data = d;
  endtask

  // Outputs are sampled on negedges, half a cycle after the DUT updates.
  task automatic waitAck(output int waited);
    waited = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        waited = i;
        return;
      end
    end
    checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic captureFrame(output logic [9:0] bits, output int busyCnt, output int ackCnt);
    bits    = '0;
    busyCnt = 0;
    ackCnt  = 0;
    for (int cyc = 0; cyc <= FRAME; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy) busyCnt++;
      if (ack != '0) ackCnt++;
      if (cyc % BD == BD / 2) bits[cyc / BD] = tx_uart;
    end
  endtask

  task automatic checkFrame(input string name, input logic [7:0] b);
    logic [9:0] bits;
    int busyCnt, ackCnt;
    captureFrame(bits, busyCnt, ackCnt);
    checkOutput({name, "_bits"}, 32'(bits), 32'({1'b1, b, 1'b0}));
    checkOutput({name, "_busy"}, 32'(busyCnt), 32'(FRAME));
    checkOutput({name, "_ackcnt"}, 32'(ackCnt), 32'd1);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_tx", 32'(tx_uart), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_idx", 32'(grant_idx), 32'd3);
  endtask

  initial begin
    logic [9:0] bits;
    int waited, busyCnt, ackCnt;

    vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b0110, 32'h00C35A00, 4'b0010, 2'd1, 8'h5A};
    vecs[2] = '{4'b0011, 32'h0000F00F, 4'b0001, 2'd0, 8'h0F};
    vecs[3] = '{4'b1001, 32'h8100007E, 4'b1000, 2'd3, 8'h81};
    vecs[4] = '{4'b1000, 32'h00000000, 4'b1000, 2'd3, 8'h00};
    vecs[5] = '{4'b0100, 32'h00FF0000, 4'b0100, 2'd2, 8'hFF};

    rst = 1'b1;
    applyStimulus(4'b0000, 32'h0);
    applyReset();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].req, vecs[v].data);
      waitAck(waited);
      checkOutput($sformatf("v%0d_ack", v), 32'(ack), 32'(vecs[v].expAck));
      checkOutput($sformatf("v%0d_idx", v), 32'(grant_idx), 32'(vecs[v].expIdx));
      checkOutput($sformatf("v%0d_tx0", v), 32'(tx_uart), 32'd0);
      req = req & ~ack;
      checkFrame($sformatf("v%0d", v), vecs[v].expByte);
      req = '0;
      @(negedge clk);
    end

    // All four request together; each frame follows the previous one after one idle cycle.
    applyReset();
    applyStimulus(4'b1111, 32'h44332211);
    for (int i = 0; i < 4; i++) begin
      waitAck(waited);
      checkOutput($sformatf("sim%0d_ack", i), 32'(ack), 32'(4'b0001 << i));
      if (i > 0) checkOutput($sformatf("sim%0d_gap", i), 32'(waited), 32'd1);
      req = req & ~ack;
      checkFrame($sformatf("sim%0d", i), 8'(8'h11 * (i + 1)));
    end

    applyStimulus(4'b0001, 32'h00000055);
    waitAck(waited);
    checkOutput("fair0_ack", 32'(ack), 32'h1);
    req[2] = 1'b1;
    req_data[23:16] = 8'h66;
    checkFrame("fair0", 8'h55);
    waitAck(waited);
    checkOutput("fair1_ack", 32'(ack), 32'h4);
    req[2] = 1'b0;
    checkFrame("fair1", 8'h66);
    waitAck(waited);
    checkOutput("fair2_ack", 32'(ack), 32'h1);
    req[0] = 1'b0;
    checkFrame("fair2", 8'h55);
    @(negedge clk);

    applyStimulus(4'b0001, 32'h0000003C);
    waitAck(waited);
    checkOutput("ign_ack", 32'(ack), 32'h1);
    fork
      captureFrame(bits, busyCnt, ackCnt);
      begin
        repeat (10) @(negedge clk);
        req_data[7:0] = 8'hFF;
      end
    join
    req = '0;
    checkOutput("ign_bits", 32'(bits), 32'({1'b1, 8'h3C, 1'b0}));
    checkOutput("ign_ackcnt", 32'(ackCnt), 32'd1);
    @(negedge clk);

    applyStimulus(4'b0001, 32'h000000C3);
    waitAck(waited);
    req = '0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_tx", 32'(tx_uart), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_ack", 32'(ack), 32'd0);
    checkOutput("mid_idx", 32'(grant_idx), 32'd3);
    applyStimulus(4'b0100, 32'h00960000);
    waitAck(waited);
    checkOutput("post_ack", 32'(ack), 32'h4);
    checkOutput("post_idx", 32'(grant_idx), 32'd2);
    req = '0;
    checkFrame("post", 8'h96);
    @(negedge clk);

    applyStimulus(4'b0001, 32'h00000099);
    waitAck(waited);
    checkOutput("wd_ack", 32'(ack), 32'h1);
    req = '0;
    fork
      captureFrame(bits, busyCnt, ackCnt);
      begin
        repeat (10) @(negedge clk);
        req[1] = 1'b1;
        repeat (10) @(negedge clk);
        req[1] = 1'b0;
      end
    join
    checkOutput("wd_bits", 32'(bits), 32'({1'b1, 8'h99, 1'b0}));
    busyCnt = 0;
    ackCnt  = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (ack != '0) ackCnt++;
    end
    checkOutput("wd_noack", 32'(ackCnt), 32'd0);
    checkOutput("wd_nobusy", 32'(busyCnt), 32'd0);
    checkOutput("wd_idx", 32'(grant_idx), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
